lsu_hs: RTL

Handshaked, parametrised load/store unit that replaces the single-cycle LSU once data memory becomes a multi-cycle SRAM. It sits between the core's memory stage and two targets: an external word-addressed data memory with a req/ack handshake, and the single-cycle peripheral bus. It performs byte-lane alignment, sign/zero extension, misalignment detection and ack timeout. It tells the core to stall through a ready/valid handshake.

---
 rtl/lsu_hs.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_hs.sv
// Handshaked load/store unit: byte-lane alignment, sign/zero extension,
// misalignment detection and ack timeout in front of a req/ack SRAM and a peripheral bus.
module lsu_hs #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_bmask,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              peri_we,
  output logic [7:0]        peri_addr,
  output logic [31:0]       peri_wdata,
  output logic [3:0]        peri_bmask,
  input  logic [31:0]       peri_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_bmask_q, mem_bmask_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic        misalign;
  logic        is_peri;
  logic        accept_peri;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_bmask;

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   return uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  assign misalign = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign is_peri  = req_addr[ADDR_W-2];

  always_comb begin
    lane_wdata = req_wdata;
    lane_bmask = 4'b1111;
    case (req_size)
      2'b00: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_bmask = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{req_wdata[15:0]}};
        lane_bmask = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Peripheral strobes are combinational in the accepting cycle and gated off during reset.
  assign accept_peri = rst && (state_q == IDLE) && req_valid && !misalign && is_peri;
  assign peri_we     = accept_peri && req_we;
  assign peri_addr   = accept_peri ? req_addr[7:0] : 8'h00;
  assign peri_wdata  = accept_peri ? lane_wdata : 32'h0;
  assign peri_bmask  = accept_peri ? lane_bmask : 4'h0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_bmask_d  = mem_bmask_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (is_peri) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = req_we ? 32'h0
                                  : load_align(peri_rdata, req_addr[1:0], req_size, req_unsigned);
          end else begin
            state_d     = MEM_WAIT;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[ADDR_W-1:2];
            mem_wdata_d = lane_wdata;
            mem_bmask_d = lane_bmask;
            off_d       = req_addr[1:0];
            size_d      = req_size;
            uns_d       = req_unsigned;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_we_q ? 32'h0 : load_align(mem_rdata, off_q, size_q, uns_q);
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_bmask_q  <= 4'h0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_bmask_q  <= mem_bmask_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_bmask  = mem_bmask_q;

endmodule
